// File: rtl/lasernet_msg_pkg.sv
// Shared constants and types for the line-editing / message-send path.
// The capacity, character codes and controller state encoding live here.
package lasernet_msg_pkg;

    localparam int MSG_CHARS = 16;

    localparam logic [7:0] ASCII_CR       = 8'h0D;
    localparam logic [7:0] ASCII_BS       = 8'h08;
    localparam logic [7:0] ASCII_SP       = 8'h20;
    localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
    localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

    typedef enum logic {
        COMPOSE = 1'b0,
        SEND    = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
    endfunction

endpackage

// File: rtl/msg_char_buffer.sv
// Fixed-capacity character buffer with append / pop / clear commands.
// The caller guarantees commands are exclusive and never overflow or underflow.
module msg_char_buffer #(
    parameter int MSG_CHARS = lasernet_msg_pkg::MSG_CHARS,
    parameter int CW        = $clog2(MSG_CHARS + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   append,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [7:0]             ch,
    output logic [8*MSG_CHARS-1:0] cstring,
    output logic [CW-1:0]          char_count
);
    import lasernet_msg_pkg::*;

    logic [7:0] slots [MSG_CHARS];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < MSG_CHARS; i++) slots[i] <= ASCII_SP;
            char_count <= '0;
        end else if (append) begin
            for (int i = 0; i < MSG_CHARS; i++)
                if (char_count == CW'(i)) slots[i] <= ch;
            char_count <= char_count + CW'(1);
        end else if (pop) begin
            // The vacated slot is the one just below the current count.
            for (int i = 0; i < MSG_CHARS; i++)
                if (char_count == CW'(i + 1)) slots[i] <= ASCII_SP;
            char_count <= char_count - CW'(1);
        end
    end

    // Character 0 sits in the most significant byte.
    for (genvar g = 0; g < MSG_CHARS; g++) begin : g_pack
        assign cstring[8*(MSG_CHARS-1-g) +: 8] = slots[g];
    end

endmodule

// File: rtl/msg_composer.sv
// Line editor between the ASCII decoder and the message transmitter:
// classifies character strobes, edits the buffer, and offers a snapshot on CR.
module msg_composer #(
    parameter int MSG_CHARS = lasernet_msg_pkg::MSG_CHARS,
    parameter int CW        = $clog2(MSG_CHARS + 1)
) (
    input  logic                   clock_65mhz,
    input  logic                   reset,
    input  logic [7:0]             ascii,
    input  logic                   ascii_ready,
    output logic [8*MSG_CHARS-1:0] cstring,
    output logic [CW-1:0]          char_count,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic [8*MSG_CHARS-1:0] msg_data,
    output logic [CW-1:0]          msg_len,
    output logic                   busy,
    output logic                   drop
);
    import lasernet_msg_pkg::*;

    state_t state, state_nxt;
    logic   append, pop, clear, snap, drop_nxt;
    logic   full, empty;

    assign full      = (char_count == CW'(MSG_CHARS));
    assign empty     = (char_count == '0);
    assign msg_valid = (state == SEND);
    assign busy      = (state == SEND);

    msg_char_buffer #(
        .MSG_CHARS (MSG_CHARS),
        .CW        (CW)
    ) u_buf (
        .clk        (clock_65mhz),
        .reset      (reset),
        .append     (append),
        .pop        (pop),
        .clear      (clear),
        .ch         (ascii),
        .cstring    (cstring),
        .char_count (char_count)
    );

    always_comb begin
        state_nxt = state;
        append    = 1'b0;
        pop       = 1'b0;
        clear     = 1'b0;
        snap      = 1'b0;
        drop_nxt  = 1'b0;
        case (state)
            COMPOSE: begin
                if (ascii_ready) begin
                    if (is_printable(ascii)) begin
                        if (full) drop_nxt = 1'b1;
                        else      append   = 1'b1;
                    end else if (ascii == ASCII_BS) begin
                        pop = !empty;
                    end else if (ascii == ASCII_CR) begin
                        // An empty line is silently ignored rather than sent.
                        if (!empty) begin
                            snap      = 1'b1;
                            state_nxt = SEND;
                        end
                    end else begin
                        drop_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                // Input is never queued while a message is outstanding.
                drop_nxt = ascii_ready;
                if (msg_ready) begin
                    clear     = 1'b1;
                    state_nxt = COMPOSE;
                end
            end
            default: state_nxt = COMPOSE;
        endcase
    end

    always_ff @(posedge clock_65mhz) begin
        if (reset) begin
            state    <= COMPOSE;
            drop     <= 1'b0;
            msg_data <= '0;
            msg_len  <= '0;
        end else begin
            state <= state_nxt;
            drop  <= drop_nxt;
            if (snap) begin
                msg_data <= cstring;
                msg_len  <= char_count;
            end
        end
    end

endmodule
